// File: rtl/pmem_arbiter_pkg.sv
// pmem_arbiter_pkg
//   Shared types for the I/D cacheline memory arbiter.
//   - arb_state_t : arbiter FSM state (also exposed as a debug output)
//   - arb_req_t   : identity of a requester, used to remember the last grant
//   - PMEM_ADDR_W / PMEM_LINE_W : default port widths
package pmem_arbiter_pkg;

    localparam int PMEM_ADDR_W = 32;
    localparam int PMEM_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } arb_req_t;

endpackage

// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if
//   Bundles the three cacheline-level ports that meet at the arbiter:
//   the I-cache port (read-only), the D-cache port and the downstream
//   port towards cacheline_adaptor.
//
//   Handshake: a requester raises x_read/x_write with a stable address
//   (and write data) and holds them until x_resp pulses for one cycle;
//   x_rdata is valid only in that cycle. The downstream port follows the
//   same rule with pmem_* and pmem_resp. There is no separate ready signal.
//
//   Modports:
//   - slave  : the arbiter (accepts cache requests, drives downstream)
//   - master : the environment (caches and adaptor)
interface pmem_arbiter_if
    import pmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = PMEM_ADDR_W,
    parameter int LINE_W = PMEM_LINE_W
) ();

    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_address, d_wdata,
        output d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Round-robin arbiter sharing one cacheline memory port between the
//   I-cache and the D-cache. The granted request is registered onto the
//   downstream port one cycle after it is seen in IDLE; the completion
//   from downstream is passed straight back to the winner.
//
//   Ports:
//   - clk   : clock
//   - rst   : synchronous active-high reset
//   - bus   : pmem_arbiter_if.slave (I-cache, D-cache and downstream ports)
//   - state : current FSM state, for debug/observation
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = PMEM_ADDR_W,
    parameter int LINE_W = PMEM_LINE_W
) (
    input  logic         clk,
    input  logic         rst,
    pmem_arbiter_if.slave bus,
    output arb_state_t   state
);

    arb_req_t          last_grant;
    logic              read_q;
    logic              write_q;
    logic [ADDR_W-1:0] address_q;
    logic [LINE_W-1:0] wdata_q;

    logic i_req;
    logic d_req;
    logic grant_i;

    always_comb begin
        i_req   = bus.i_read;
        d_req   = bus.d_read | bus.d_write;
        // On a tie the requester that did not win last time goes first.
        grant_i = i_req && (!d_req || (last_grant == REQ_D));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= REQ_D;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            address_q  <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state      <= SERVE_I;
                        last_grant <= REQ_I;
                        address_q  <= bus.i_address;
                        read_q     <= 1'b1;
                        write_q    <= 1'b0;
                    end else if (d_req) begin
                        state      <= SERVE_D;
                        last_grant <= REQ_D;
                        address_q  <= bus.d_address;
                        wdata_q    <= bus.d_wdata;
                        // A simultaneous read+write is treated as a write.
                        write_q    <= bus.d_write;
                        read_q     <= ~bus.d_write;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Downstream outputs hold until the completion arrives.
                    if (bus.pmem_resp) begin
                        state   <= IDLE;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.pmem_read    = read_q;
        bus.pmem_write   = write_q;
        bus.pmem_address = address_q;
        bus.pmem_wdata   = wdata_q;
        // Read data is broadcast; only the completion pulse is steered.
        bus.i_rdata      = bus.pmem_rdata;
        bus.d_rdata      = bus.pmem_rdata;
        bus.i_resp       = (state == SERVE_I) && bus.pmem_resp;
        bus.d_resp       = (state == SERVE_D) && bus.pmem_resp;
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter
//   Directed self-checking bench for pmem_arbiter. Inputs are driven 1 ns
//   after each rising edge; registered outputs are checked there and
//   combinational responses 1 ns after the inputs change.
module tb_pmem_arbiter;
    import pmem_arbiter_pkg::*;

    localparam int ADDR_W = PMEM_ADDR_W;
    localparam int LINE_W = PMEM_LINE_W;

    logic       clk;
    logic       rst;
    arb_state_t state;

    pmem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .state (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Illegal D-cache input combination must never be driven.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.d_read && bus.d_write))
                else $error("d_read and d_write asserted together");
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string tag, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_read     = 1'b0;
        bus.i_address  = '0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_address  = '0;
        bus.d_wdata    = '0;
        bus.pmem_rdata = '0;
        bus.pmem_resp  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    // Pulse pmem_resp for one cycle; the combinational resp is checked mid-cycle.
    task automatic pulse_resp(input logic [LINE_W-1:0] rdata, input logic exp_i,
                              input logic exp_d, input string tag);
        bus.pmem_rdata = rdata;
        bus.pmem_resp  = 1'b1;
        #1;
        check({tag, "_i_resp"}, bus.i_resp, exp_i);
        check({tag, "_d_resp"}, bus.d_resp, exp_d);
        if (exp_i) check({tag, "_i_rdata"}, bus.i_rdata, rdata);
        if (exp_d) check({tag, "_d_rdata"}, bus.d_rdata, rdata);
        step();
        bus.pmem_resp = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [LINE_W-1:0] line_aa;
    logic [LINE_W-1:0] line_w;
    logic [1:0]        exp_st;

    initial begin
        line_aa = {(LINE_W/8){8'hAA}};
        line_w  = {(LINE_W/32){32'h1234_5678}};
        rst = 1'b1;
        idle_inputs();

        // Reset values
        do_reset();
        check("rst_state", state, IDLE);
        check("rst_pmem_read", bus.pmem_read, 1'b0);
        check("rst_pmem_write", bus.pmem_write, 1'b0);
        check("rst_pmem_address", bus.pmem_address, '0);
        check("rst_pmem_wdata", bus.pmem_wdata, '0);
        check("rst_i_resp", bus.i_resp, 1'b0);
        check("rst_d_resp", bus.d_resp, 1'b0);

        // Single I-cache read
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_0060;
        step();
        check("i_rd_state", state, SERVE_I);
        check("i_rd_pmem_read", bus.pmem_read, 1'b1);
        check("i_rd_pmem_write", bus.pmem_write, 1'b0);
        check("i_rd_pmem_address", bus.pmem_address, 32'h60);
        step();
        step();
        check("i_rd_hold_read", bus.pmem_read, 1'b1);
        pulse_resp(line_aa, 1'b1, 1'b0, "i_rd");
        bus.i_read = 1'b0;
        check("i_rd_after_read", bus.pmem_read, 1'b0);
        check("i_rd_after_state", state, IDLE);
        check("i_rd_after_i_resp", bus.i_resp, 1'b0);

        // D-cache writeback held through 10 wait cycles
        bus.d_write   = 1'b1;
        bus.d_address = 32'h0000_0100;
        bus.d_wdata   = line_w;
        step();
        check("d_wr_state", state, SERVE_D);
        check("d_wr_pmem_address", bus.pmem_address, 32'h100);
        check("d_wr_pmem_wdata", bus.pmem_wdata, line_w);
        for (int k = 0; k < 10; k++) begin
            check("d_wr_hold_write", bus.pmem_write, 1'b1);
            check("d_wr_hold_read", bus.pmem_read, 1'b0);
            step();
        end
        check("d_wr_hold_address", bus.pmem_address, 32'h100);
        pulse_resp('0, 1'b0, 1'b1, "d_wr");
        bus.d_write = 1'b0;
        check("d_wr_after_write", bus.pmem_write, 1'b0);
        check("d_wr_after_d_resp", bus.d_resp, 1'b0);

        // Simultaneous requests after reset: I first, then D
        do_reset();
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_0200;
        bus.d_read    = 1'b1;
        bus.d_address = 32'h0000_0300;
        step();
        check("tie_first_state", state, SERVE_I);
        check("tie_first_address", bus.pmem_address, 32'h200);
        step();
        pulse_resp(line_aa, 1'b1, 1'b0, "tie_i");
        bus.i_read = 1'b0;
        check("tie_bubble_state", state, IDLE);
        check("tie_bubble_read", bus.pmem_read, 1'b0);
        step();
        check("tie_second_state", state, SERVE_D);
        check("tie_second_address", bus.pmem_address, 32'h300);
        check("tie_second_read", bus.pmem_read, 1'b1);
        pulse_resp(line_w, 1'b0, 1'b1, "tie_d");
        bus.d_read = 1'b0;
        step();

        // Both held for 6 transactions: grants alternate starting with I
        for (int k = 0; k < 6; k++) exp_q.push_back((k % 2 == 0) ? SERVE_I : SERVE_D);
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_1000;
        bus.d_read    = 1'b1;
        bus.d_address = 32'h0000_2000;
        while (exp_q.size() > 0) begin
            exp_st = exp_q.pop_front();
            step();
            check("rr_grant", state, exp_st);
            check("rr_address", bus.pmem_address,
                  (exp_st == SERVE_I) ? 32'h1000 : 32'h2000);
            pulse_resp(line_aa, exp_st == SERVE_I, exp_st == SERVE_D, "rr");
            check("rr_idle", state, IDLE);
        end
        idle_inputs();
        step();

        // Reset two cycles into a D read
        bus.d_read    = 1'b1;
        bus.d_address = 32'h0000_0400;
        step();
        check("mid_rst_serving", state, SERVE_D);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.d_read = 1'b0;
        check("mid_rst_state", state, IDLE);
        check("mid_rst_pmem_read", bus.pmem_read, 1'b0);
        check("mid_rst_address", bus.pmem_address, '0);
        pulse_resp(line_aa, 1'b0, 1'b0, "mid_rst_late");

        // pmem_resp while idle with no requests
        step();
        pulse_resp(line_w, 1'b0, 1'b0, "idle_resp");
        check("idle_resp_state", state, IDLE);
        check("idle_resp_read", bus.pmem_read, 1'b0);
        check("idle_resp_write", bus.pmem_write, 1'b0);
        check("idle_resp_address", bus.pmem_address, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        n_errors++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
